// File: rtl/sample_gain_ramp.sv
// sample_gain_ramp: pull-driven gain stage between the DDS sample source and
// the I2S transmitter. Each transmitter request is forwarded to the DDS. Each
// returned sample is scaled by a gain that moves linearly toward the target,
// one step per sample. The scaled sample is driven on both L and R.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_HOLD | cur_gain equals the effective target, ramping=0
// S_UP   | cur_gain below the effective target, gain rises per sample
// S_DOWN | cur_gain above the effective target, gain falls per sample
module sample_gain_ramp #(
  parameter int DW     = 24,
  parameter int GW     = 16,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GW-1:0]     target_gain,
  input  logic [STEP_W-1:0] step,
  input  logic              mute,
  input  logic              snk_rd_en,
  output logic              snk_valid,
  output logic [DW-1:0]     l_sample,
  output logic [DW-1:0]     r_sample,
  output logic              src_ce,
  input  logic              src_valid,
  input  logic [DW-1:0]     src_sample,
  output logic              ramping,
  output logic              overrun
);

  localparam int PW = DW + GW + 1;

  // Half an LSB of the output, added before the shift so rounding is half up.
  localparam logic signed [PW-1:0] RND_K =
    {{(PW-GW+1){1'b0}}, 1'b1, {(GW-2){1'b0}}};
  localparam logic signed [PW-1:0] MAX_V =
    {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_V =
    {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              outstanding_q, outstanding_d;
  logic              overrun_q, overrun_d;
  logic              src_ce_q, src_ce_d;
  logic              accept;

  logic [GW-1:0]     cur_gain_q, cur_gain_d;
  logic [GW-1:0]     t_gain;
  logic [GW:0]       sum_up;
  logic [GW-1:0]     diff_dn;
  logic [GW-1:0]     step_ext;

  logic signed [PW-1:0] prod_q, prod_d;
  logic              vld1_q, vld1_d;
  logic signed [PW-1:0] rnd;
  logic signed [PW-1:0] shf;
  logic [DW-1:0]     sat;
  logic [DW-1:0]     sample_q, sample_d;
  logic              snk_valid_q, snk_valid_d;

  assign t_gain   = mute ? '0 : target_gain;
  assign step_ext = {{(GW-STEP_W){1'b0}}, step};

  // Request handshake. A response arriving in the same cycle frees the slot,
  // so a simultaneous new request is accepted rather than flagged.
  always_comb begin
    accept        = snk_rd_en && (!outstanding_q || src_valid);
    src_ce_d      = accept;
    overrun_d     = overrun_q || (snk_rd_en && !accept);
    outstanding_d = outstanding_q;
    if (src_valid) outstanding_d = 1'b0;
    if (accept)    outstanding_d = 1'b1;
  end

  // Request-path registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding_q <= 1'b0;
      overrun_q     <= 1'b0;
      src_ce_q      <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      overrun_q     <= overrun_d;
      src_ce_q      <= src_ce_d;
    end
  end

  // Next gain. Compared against the live target every cycle so that a target
  // or mute change redirects the ramp immediately; it moves only on samples.
  always_comb begin
    cur_gain_d = cur_gain_q;
    sum_up     = {1'b0, cur_gain_q} + {1'b0, step_ext};
    diff_dn    = cur_gain_q - t_gain;
    if (src_valid) begin
      if (cur_gain_q < t_gain) begin
        cur_gain_d = (sum_up > {1'b0, t_gain}) ? t_gain : sum_up[GW-1:0];
      end else if (cur_gain_q > t_gain) begin
        cur_gain_d = (diff_dn <= step_ext) ? t_gain : (cur_gain_q - step_ext);
      end
    end
    if (cur_gain_d < t_gain)      state_d = S_UP;
    else if (cur_gain_d > t_gain) state_d = S_DOWN;
    else                          state_d = S_HOLD;
  end

  // Gain ramp FSM and gain register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_HOLD;
      cur_gain_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_gain_q <= cur_gain_d;
    end
  end

  // Stage 1: signed product, using the gain from before this sample's update.
  always_comb begin
    vld1_d = src_valid;
    prod_d = prod_q;
    if (src_valid) begin
      prod_d = $signed({{(GW+1){src_sample[DW-1]}}, src_sample}) *
               $signed({{(DW+1){1'b0}}, cur_gain_q});
    end
  end

  // Stage 2: round half up, shift down to sample scale, saturate.
  always_comb begin
    rnd = prod_q + RND_K;
    shf = rnd >>> (GW-1);
    if (shf > MAX_V)      sat = MAX_V[DW-1:0];
    else if (shf < MIN_V) sat = MIN_V[DW-1:0];
    else                  sat = shf[DW-1:0];
    sample_d    = vld1_q ? sat : sample_q;
    snk_valid_d = vld1_q;
  end

  // Datapath pipeline registers; reset drops any sample in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q      <= '0;
      vld1_q      <= 1'b0;
      sample_q    <= '0;
      snk_valid_q <= 1'b0;
    end else begin
      prod_q      <= prod_d;
      vld1_q      <= vld1_d;
      sample_q    <= sample_d;
      snk_valid_q <= snk_valid_d;
    end
  end

  assign src_ce    = src_ce_q;
  assign overrun   = overrun_q;
  assign snk_valid = snk_valid_q;
  assign l_sample  = sample_q;
  assign r_sample  = sample_q;
  assign ramping   = (state_q != S_HOLD);

endmodule

// File: tb/tb_sample_gain_ramp.sv
// Randomized bench for sample_gain_ramp: a DDS responder with random latency
// and a per-sample arithmetic model of the gain ramp and scaling.
module tb_sample_gain_ramp;

  logic               clk = 1'b0;
  logic               rst;
  logic [15:0]        target_gain;
  logic [7:0]         step;
  logic               mute;
  logic               snk_rd_en;
  logic               snk_valid;
  logic signed [23:0] l_sample;
  logic signed [23:0] r_sample;
  logic               src_ce;
  logic               src_valid;
  logic [23:0]        src_sample;
  logic               ramping;
  logic               overrun;

  int n_checks = 0;
  int n_errors = 0;

  int mdl_gain = 0;
  int tgt = 0;
  int stp = 0;
  bit mt = 1'b0;

  sample_gain_ramp #(.DW(24), .GW(16), .STEP_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .target_gain (target_gain),
    .step        (step),
    .mute        (mute),
    .snk_rd_en   (snk_rd_en),
    .snk_valid   (snk_valid),
    .l_sample    (l_sample),
    .r_sample    (r_sample),
    .src_ce      (src_ce),
    .src_valid   (src_valid),
    .src_sample  (src_sample),
    .ramping     (ramping),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int eff_t();
    return mt ? 0 : tgt;
  endfunction

  function automatic int next_gain(int g, int t, int s);
    if (g < t) return (g + s > t) ? t : g + s;
    if (g > t) return (g - t <= s) ? t : g - s;
    return g;
  endfunction

  function automatic longint scale(int smp, int g);
    longint p;
    p = longint'(smp) * longint'(g);
    p = (p + 16384) >>> 15;
    if (p > 8388607) p = 8388607;
    else if (p < -8388608) p = -8388608;
    return p;
  endfunction

  function automatic int rnd_smp();
    return int'($urandom_range(0, 16777215)) - 8388608;
  endfunction

  task automatic set_cfg(input int t, input int s, input bit m);
    tgt = t; stp = s; mt = m;
    target_gain = t[15:0];
    step        = s[7:0];
    mute        = m;
  endtask

  // Deliver one DDS sample; optionally raise a new request in the same cycle.
  task automatic answer(input int smp, input bit with_rd);
    longint exp;
    src_valid  = 1'b1;
    src_sample = smp[23:0];
    if (with_rd) snk_rd_en = 1'b1;
    exp = scale(smp, mdl_gain);
    mdl_gain = next_gain(mdl_gain, eff_t(), stp);
    @(negedge clk);
    src_valid = 1'b0;
    if (with_rd) begin
      snk_rd_en = 1'b0;
      chk("src_ce_same_cycle", src_ce, 1);
    end
    chk("snk_valid_early", snk_valid, 0);
    @(negedge clk);
    chk("snk_valid", snk_valid, 1);
    chk("l_sample", l_sample, exp);
    chk("r_sample", r_sample, exp);
    chk("ramping", ramping, (mdl_gain != eff_t()) ? 1 : 0);
  endtask

  task automatic do_sample(input int smp, input int lat);
    snk_rd_en = 1'b1;
    @(negedge clk);
    snk_rd_en = 1'b0;
    chk("src_ce", src_ce, 1);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk("src_ce_pulse", src_ce, 0);
    end
    answer(smp, 1'b0);
  endtask

  task automatic settle();
    int guard = 0;
    while (mdl_gain != eff_t() && guard < 600) begin
      do_sample(rnd_smp(), int'($urandom_range(1, 4)));
      guard++;
    end
  endtask

  initial begin
    rst = 1'b0;
    snk_rd_en = 1'b0;
    src_valid = 1'b0;
    src_sample = '0;
    set_cfg(16'h8000, 8'h80, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_snk_valid", snk_valid, 0);
    chk("rst_l_sample", l_sample, 0);
    chk("rst_r_sample", r_sample, 0);
    chk("rst_src_ce", src_ce, 0);
    chk("rst_ramping", ramping, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b1;
    @(negedge clk);

    // Soft start: 256 steps of 0x80 reach unity.
    for (int i = 0; i < 257; i++) do_sample(1000, int'($urandom_range(1, 4)));
    chk("t1_unity_out", l_sample, 1000);
    chk("t1_ramping", ramping, 0);

    // Saturation at maximum gain.
    set_cfg(16'hFFFF, 8'hFF, 1'b0);
    while (mdl_gain != eff_t()) do_sample(-8388608, 1);
    do_sample(-8388608, 2);
    chk("t2_neg_clamp", l_sample, -8388608);
    do_sample(8388607, 2);
    chk("t2_pos_clamp", l_sample, 8388607);

    // Mute ramp down from unity in 512 samples, then back up.
    set_cfg(16'h8000, 8'hFF, 1'b0);
    settle();
    set_cfg(16'h8000, 8'h40, 1'b1);
    for (int i = 0; i < 512; i++) do_sample(1000, 1);
    do_sample(1000, 1);
    chk("t3_muted_out", l_sample, 0);
    chk("t3_muted_ramping", ramping, 0);
    set_cfg(16'h8000, 8'h40, 1'b0);
    settle();
    do_sample(1000, 1);
    chk("t3_unmuted_out", l_sample, 1000);

    // Rounding at half gain.
    set_cfg(16'h4000, 8'hFF, 1'b0);
    settle();
    do_sample(3, 1);
    chk("t5_round_pos", l_sample, 2);
    do_sample(-3, 1);
    chk("t5_round_neg", l_sample, -1);

    // Overrun and simultaneous request/response.
    chk("t4_overrun_clear", overrun, 0);
    snk_rd_en = 1'b1;
    @(negedge clk);
    snk_rd_en = 1'b0;
    chk("t4_src_ce", src_ce, 1);
    @(negedge clk);
    chk("t4_src_ce_low", src_ce, 0);
    snk_rd_en = 1'b1;
    @(negedge clk);
    snk_rd_en = 1'b0;
    chk("t4_src_ce_blocked", src_ce, 0);
    chk("t4_overrun_set", overrun, 1);
    answer(rnd_smp(), 1'b0);
    snk_rd_en = 1'b1;
    @(negedge clk);
    snk_rd_en = 1'b0;
    chk("t4_src_ce2", src_ce, 1);
    @(negedge clk);
    answer(rnd_smp(), 1'b1);
    answer(rnd_smp(), 1'b0);
    chk("t4_overrun_sticky", overrun, 1);

    // Random targets, steps, mute and DDS latency.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        set_cfg(int'($urandom_range(0, 65535)),
                ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 255)),
                ($urandom_range(0, 5) == 0));
      end
      do_sample(rnd_smp(), int'($urandom_range(1, 4)));
    end

    // Reset with a sample in flight.
    snk_rd_en = 1'b1;
    @(negedge clk);
    snk_rd_en = 1'b0;
    @(negedge clk);
    src_valid = 1'b1;
    src_sample = 24'd1000;
    @(negedge clk);
    src_valid = 1'b0;
    rst = 1'b0;
    mdl_gain = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t6_snk_valid", snk_valid, 0);
      chk("t6_l_sample", l_sample, 0);
      chk("t6_r_sample", r_sample, 0);
      chk("t6_src_ce", src_ce, 0);
      chk("t6_ramping", ramping, 0);
      chk("t6_overrun", overrun, 0);
      @(negedge clk);
    end
    set_cfg(16'h8000, 8'h80, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_no_late_valid", snk_valid, 0);
    do_sample(1000, 2);
    chk("t6_restart_zero", l_sample, 0);
    do_sample(1000, 2);
    chk("t6_restart_step", l_sample, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
